// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
//   Captures one padded 512-bit block and streams the SHA-256 message
//   schedule words W[0..ROUNDS-1], one per valid/ready handshake. A 16-word
//   sliding window holds W[idx..idx+15], so one expansion adder tree is
//   shared by every round.
//
// Ports
//   clk, rst_n    rising-edge clock, async active-low reset
//   start         1-cycle pulse, captures block_in (honoured in IDLE only)
//   abort         drop the current block, back to IDLE (beats start/handshake)
//   block_in      W[0] = [511:480] ... W[15] = [31:0]
//   w_out, w_idx  current schedule word and its round index
//   w_valid       w_out/w_idx valid (registered)
//   w_ready       consumer accepts word when w_valid && w_ready
//   busy          high while a block is being emitted
//   done          1-cycle pulse after word ROUNDS-1 is accepted
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] block_in,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_valid,
  input  logic         w_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t            state;
  logic [15:0][31:0] window;   // window[k] = W[idx+k]
  logic [5:0]        idx;
  logic [31:0]       w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // W[idx+16], the word that enters the window on the next shift
  assign w_next = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];

  // window[0] and idx are registers, so nothing here depends on w_ready
  assign w_out = window[0];
  assign w_idx = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      window  <= '0;
      idx     <= '0;
      w_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        idx     <= '0;
        w_valid <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              for (int k = 0; k < 16; k++)
                window[k] <= block_in[511-32*k -: 32];
              idx     <= '0;
              state   <= RUN;
              w_valid <= 1'b1;
              busy    <= 1'b1;
            end
          end
          RUN: begin
            if (w_ready) begin
              window <= {w_next, window[15:1]};
              if (idx == LAST) begin
                state   <= IDLE;
                idx     <= '0;
                w_valid <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                idx <= idx + 6'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule. Expected words come from a
// flat W[t] recurrence model plus hand-known "abc" schedule constants.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         start = 1'b0, start16 = 1'b0, abort = 1'b0, w_ready = 1'b0;
  logic [511:0] block_in = '0;
  logic [31:0]  w_out, w_out16;
  logic [5:0]   w_idx, w_idx16;
  logic         w_valid, w_valid16, busy, busy16, done, done16;

  logic         sel = 1'b0;   // 1: observe the ROUNDS=16 instance
  logic [31:0]  s_out;
  logic [5:0]   s_idx;
  logic         s_valid, s_busy, s_done;

  int           n_chk = 0, n_err = 0;
  logic [31:0]  exp_w [64];

  localparam logic [511:0] ABC  = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] ZERO = '0;

  always #5 clk = ~clk;

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .block_in(block_in),
    .w_out(w_out), .w_idx(w_idx), .w_valid(w_valid), .w_ready(w_ready),
    .busy(busy), .done(done));

  sha256_msg_schedule #(.ROUNDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort), .block_in(block_in),
    .w_out(w_out16), .w_idx(w_idx16), .w_valid(w_valid16), .w_ready(w_ready),
    .busy(busy16), .done(done16));

  assign s_out   = sel ? w_out16   : w_out;
  assign s_idx   = sel ? w_idx16   : w_idx;
  assign s_valid = sel ? w_valid16 : w_valid;
  assign s_busy  = sel ? busy16    : busy;
  assign s_done  = sel ? done16    : done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic model(input logic [511:0] b);
    for (int t = 0; t < 16; t++) exp_w[t] = 32'(b >> (32 * (15 - t)));
    for (int t = 16; t < 64; t++)
      exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_w"},      w_out,            32'h0);
    chk({tag, "_idx"},    32'(w_idx),       32'h0);
    chk({tag, "_valid"},  32'(w_valid),     32'h0);
    chk({tag, "_busy"},   32'(busy),        32'h0);
    chk({tag, "_done"},   32'(done),        32'h0);
    chk({tag, "_w16"},    w_out16,          32'h0);
    chk({tag, "_vld16"},  32'(w_valid16),   32'h0);
  endtask

  // Pulse start at the next edge; block_in is then scrambled to show it is
  // only sampled on the accepted start.
  task automatic do_start(input logic [511:0] b, input logic use16);
    block_in = b;
    if (use16) start16 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start16 = 1'b0;
    block_in = ~b;
  endtask

  // Entered #1 after the start edge. ev_kind: 0 none, 1 stray start,
  // 2 abort, 3 reset, fired when word ev_idx is presented.
  task automatic stream(input int mode, input int nrounds, input bit is_abc,
                        input int ev_kind, input int ev_idx);
    int k = 0, cyc = 0;
    bit fired = 0, stalled = 0;
    logic [31:0] pw = '0;
    logic [5:0]  pi = '0;
    while (k < nrounds && cyc < 2000) begin
      chk($sformatf("valid@%0d", k), 32'(s_valid), 32'h1);
      chk($sformatf("busy@%0d", k),  32'(s_busy),  32'h1);
      chk($sformatf("idx@%0d", k),   32'(s_idx),   32'(k));
      chk($sformatf("w%0d", k),      s_out,        exp_w[k]);
      if (stalled) begin
        chk("stall_w",   s_out,       pw);
        chk("stall_idx", 32'(s_idx),  32'(pi));
      end
      if (is_abc) begin
        case (k)
          0:  chk("abc_w0",  s_out, 32'h61626380);
          15: chk("abc_w15", s_out, 32'h00000018);
          16: chk("abc_w16", s_out, 32'h61626380);
          17: chk("abc_w17", s_out, 32'h000F0000);
          18: chk("abc_w18", s_out, 32'h7DA86405);
          19: chk("abc_w19", s_out, 32'h600003C6);
          63: chk("abc_w63", s_out, 32'h12B1EDEB);
          default: ;
        endcase
      end
      if (!fired && ev_kind != 0 && k == ev_idx) begin
        fired = 1;
        if (ev_kind == 1) begin
          start = 1'b1;
          block_in = {16{32'hDEADBEEF}};
        end else if (ev_kind == 2) begin
          abort = 1'b1; w_ready = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0; w_ready = 1'b0;
          chk("abort_valid", 32'(s_valid), 32'h0);
          chk("abort_busy",  32'(s_busy),  32'h0);
          chk("abort_done",  32'(s_done),  32'h0);
          chk("abort_idx",   32'(s_idx),   32'h0);
          return;
        end else begin
          rst_n = 1'b0; #1;
          chk_reset("rst_mid");
          @(posedge clk); #1;
          chk_reset("rst_hold");
          rst_n = 1'b1; w_ready = 1'b0;
          @(posedge clk); #1;
          chk("rst_nodone", 32'(done), 32'h0);
          return;
        end
      end
      if (mode == 0) w_ready = 1'b1;
      else w_ready = !((cyc >= 10 && cyc < 20) || (cyc >= 40 && cyc < 50)) &&
                     ($urandom_range(0, 2) != 0);
      stalled = !w_ready; pw = s_out; pi = s_idx;
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (w_ready) k++;
    end
    w_ready = 1'b0;
    chk("stream_count", 32'(k), 32'(nrounds));
    chk("done",       32'(s_done),  32'h1);
    chk("done_busy",  32'(s_busy),  32'h0);
    chk("done_valid", 32'(s_valid), 32'h0);
    @(posedge clk); #1;
    chk("done_pulse", 32'(s_done), 32'h0);
  endtask

  initial begin
    #12;
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset("post_reset");

    // abc, always ready
    model(ABC);  do_start(ABC, 1'b0);  stream(0, 64, 1, 0, 0);
    // all-zero block
    model(ZERO); do_start(ZERO, 1'b0); stream(0, 64, 0, 0, 0);
    // abc with back-pressure
    model(ABC);  do_start(ABC, 1'b0);  stream(1, 64, 1, 0, 0);
    // stray start at idx 20
    do_start(ABC, 1'b0); stream(0, 64, 1, 1, 20);
    // abort at idx 30, zero block two cycles later
    do_start(ABC, 1'b0); stream(0, 64, 1, 2, 30);
    @(posedge clk); #1;
    chk("abort_gap_done", 32'(done), 32'h0);
    model(ZERO); do_start(ZERO, 1'b0); stream(0, 64, 0, 0, 0);
    // reset at idx 40, then abc restart
    model(ABC);  do_start(ABC, 1'b0);  stream(0, 64, 1, 3, 40);
    do_start(ABC, 1'b0); stream(0, 64, 1, 0, 0);
    // ROUNDS=16 build
    sel = 1'b1;
    do_start(ABC, 1'b1); stream(0, 16, 1, 0, 0);
    chk("r16_main_idle", 32'(w_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
